// File: rtl/unicycle_pkg.sv
// Shared definitions for the unicycle load/store datapath: default widths
// and the load-unit FSM state encoding.
package unicycle_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 16;
   localparam int DEF_REG_W  = 4;

   typedef logic [1:0] lu_state_t;

   localparam lu_state_t ST_IDLE = 2'd0;
   localparam lu_state_t ST_REQ  = 2'd1;
   localparam lu_state_t ST_WAIT = 2'd2;
   localparam lu_state_t ST_WB   = 2'd3;

endpackage

// File: rtl/load_timeout_ctr.sv
// Watchdog counter for the load unit; only instantiated when
// LOAD_UNIT_TIMEOUT_EN is defined.
module load_timeout_ctr #(
   parameter int LIMIT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] count;

   // Saturates at the limit so a stuck transaction cannot wrap and re-arm.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (count_en && (count != CW'(LIMIT))) begin
         count <= count + 1'b1;
      end
   end

   assign expired = count_en && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/load_unit.sv
// LDR memory load unit: request, wait for data, write back to the register file.
// Optional watchdog enabled by defining LOAD_UNIT_TIMEOUT_EN.
module load_unit
   import unicycle_pkg::*;
#(
   parameter int DATA_W         = DEF_DATA_W,
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int REG_W          = DEF_REG_W,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [REG_W-1:0]  dest_in,
   output logic              busy,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              wb_en,
   output logic [REG_W-1:0]  wb_reg,
   output logic [DATA_W-1:0] wb_data,
   output logic              done,
   output logic              err
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_limit
      $error("load_unit: TIMEOUT_CYCLES must be at least 1");
   end

   lu_state_t        state;
   logic [REG_W-1:0] dest_q;
   logic             normal_exit;
   logic             timeout_fire;

   assign busy        = (state != ST_IDLE);
   assign mem_req     = (state == ST_REQ);
   assign normal_exit = ((state == ST_REQ) && mem_gnt) || ((state == ST_WAIT) && mem_rvalid);

`ifdef LOAD_UNIT_TIMEOUT_EN
   logic expired;

   load_timeout_ctr #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (clk),
      .reset    (reset),
      .clear    ((state == ST_IDLE) && start),
      .count_en ((state == ST_REQ) || (state == ST_WAIT)),
      .expired  (expired)
   );

   // A grant or data arriving on the limit cycle still completes normally.
   assign timeout_fire = expired && !normal_exit;

   always_ff @(posedge clk) begin
      if (reset) begin
         err <= 1'b0;
      end else begin
         err <= timeout_fire;
      end
   end
`else
   assign timeout_fire = 1'b0;
   assign err          = 1'b0;
`endif

   // wb_en/done are registered, so they pulse in the cycle after WB.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         mem_addr <= '0;
         dest_q   <= '0;
         wb_en    <= 1'b0;
         wb_reg   <= '0;
         wb_data  <= '0;
         done     <= 1'b0;
      end else begin
         wb_en <= 1'b0;
         done  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_REQ;
                  mem_addr <= addr_in;
                  dest_q   <= dest_in;
               end
            end
            ST_REQ: begin
               if (mem_gnt) begin
                  state <= ST_WAIT;
               end else if (timeout_fire) begin
                  state <= ST_IDLE;
                  done  <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (mem_rvalid) begin
                  state   <= ST_WB;
                  wb_data <= mem_rdata;
                  wb_reg  <= dest_q;
               end else if (timeout_fire) begin
                  state <= ST_IDLE;
                  done  <= 1'b1;
               end
            end
            ST_WB: begin
               state <= ST_IDLE;
               wb_en <= 1'b1;
               done  <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: per-cycle vector table plus hand-written
// stall and watchdog sequences (watchdog path follows LOAD_UNIT_TIMEOUT_EN).
module tb_load_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] addr_in;
   logic [3:0]  dest_in;
   logic        busy;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [15:0] mem_rdata;
   logic        wb_en;
   logic [3:0]  wb_reg;
   logic [15:0] wb_data;
   logic        done;
   logic        err;

   int nChecks = 0;
   int nFails  = 0;

   typedef struct packed {
      logic        rst;
      logic        start;
      logic [15:0] addr;
      logic [3:0]  dest;
      logic        gnt;
      logic        rvalid;
      logic [15:0] rdata;
      logic        busy;
      logic        req;
      logic [15:0] maddr;
      logic        wben;
      logic [3:0]  wbreg;
      logic [15:0] wbdata;
      logic        done;
      logic        err;
   } vec_t;

   localparam int NVEC = 26;
   vec_t vecs[NVEC];

   load_unit #(
      .DATA_W         (16),
      .ADDR_W         (16),
      .REG_W          (4),
      .TIMEOUT_CYCLES (15)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .addr_in    (addr_in),
      .dest_in    (dest_in),
      .busy       (busy),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .wb_en      (wb_en),
      .wb_reg     (wb_reg),
      .wb_data    (wb_data),
      .done       (done),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(logic r, logic s, logic [15:0] a, logic [3:0] d,
                               logic g, logic v, logic [15:0] rd,
                               logic eb, logic eq, logic [15:0] ema, logic ew,
                               logic [3:0] er, logic [15:0] ed, logic edn, logic ee);
      vec_t t;
      t.rst = r;  t.start = s; t.addr = a; t.dest = d;
      t.gnt = g;  t.rvalid = v; t.rdata = rd;
      t.busy = eb; t.req = eq; t.maddr = ema; t.wben = ew;
      t.wbreg = er; t.wbdata = ed; t.done = edn; t.err = ee;
      return t;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic driveInputs(input logic r, input logic s, input logic [15:0] a, input logic [3:0] d,
                              input logic g, input logic v, input logic [15:0] rd);
      @(negedge clk);
      reset = r; start = s; addr_in = a; dest_in = d;
      mem_gnt = g; mem_rvalid = v; mem_rdata = rd;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      logic [40:0] act;
      logic [40:0] exp;
      driveInputs(v.rst, v.start, v.addr, v.dest, v.gnt, v.rvalid, v.rdata);
      act = {busy, mem_req, mem_addr, wb_en, wb_reg, wb_data, done, err};
      exp = {v.busy, v.req, v.maddr, v.wben, v.wbreg, v.wbdata, v.done, v.err};
      checkOutput($sformatf("vec%0d", idx), 64'(act), 64'(exp));
   endtask

   initial begin
      int reqCycles;
      int wbCount;
      int errCount;
      int busyLow;
      logic [19:0] wbSeen;
      logic sawDone;
      logic doneErr;
      logic doneWb;

      reset = 1'b0; start = 1'b0; addr_in = '0; dest_in = '0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

      // rst start addr dest gnt rvalid rdata | busy req maddr wben wbreg wbdata done err
      vecs[0]  = mk(1,0,16'h0000,0,0,0,16'h0000, 0,0,16'h0000,0,0,16'h0000,0,0);
      vecs[1]  = mk(0,1,16'h0040,3,0,0,16'h0000, 1,1,16'h0040,0,0,16'h0000,0,0);
      vecs[2]  = mk(0,0,16'h0000,0,1,0,16'h0000, 1,0,16'h0040,0,0,16'h0000,0,0);
      vecs[3]  = mk(0,0,16'h0000,0,0,1,16'hBEEF, 1,0,16'h0040,0,3,16'hBEEF,0,0);
      vecs[4]  = mk(0,0,16'h0000,0,0,0,16'h0000, 0,0,16'h0040,1,3,16'hBEEF,1,0);
      vecs[5]  = mk(0,0,16'h0000,0,0,0,16'h0000, 0,0,16'h0040,0,3,16'hBEEF,0,0);
      vecs[6]  = mk(0,1,16'h0100,5,0,0,16'h0000, 1,1,16'h0100,0,3,16'hBEEF,0,0);
      vecs[7]  = mk(0,0,16'h0000,0,0,1,16'hDEAD, 1,1,16'h0100,0,3,16'hBEEF,0,0);
      vecs[8]  = mk(0,0,16'h0000,0,1,1,16'hDEAD, 1,0,16'h0100,0,3,16'hBEEF,0,0);
      vecs[9]  = mk(0,1,16'h1234,7,0,0,16'h0000, 1,0,16'h0100,0,3,16'hBEEF,0,0);
      vecs[10] = mk(0,0,16'h0000,0,0,1,16'h1357, 1,0,16'h0100,0,5,16'h1357,0,0);
      vecs[11] = mk(0,0,16'h0000,0,0,0,16'h0000, 0,0,16'h0100,1,5,16'h1357,1,0);
      vecs[12] = mk(0,0,16'h0000,0,0,0,16'h0000, 0,0,16'h0100,0,5,16'h1357,0,0);
      vecs[13] = mk(0,1,16'h0200,1,0,0,16'h0000, 1,1,16'h0200,0,5,16'h1357,0,0);
      vecs[14] = mk(0,0,16'h0000,0,1,0,16'h0000, 1,0,16'h0200,0,5,16'h1357,0,0);
      vecs[15] = mk(0,0,16'h0000,0,0,1,16'hA5A5, 1,0,16'h0200,0,1,16'hA5A5,0,0);
      vecs[16] = mk(0,1,16'h0300,2,0,0,16'h0000, 0,0,16'h0200,1,1,16'hA5A5,1,0);
      vecs[17] = mk(0,1,16'h0300,2,0,0,16'h0000, 1,1,16'h0300,0,1,16'hA5A5,0,0);
      vecs[18] = mk(0,0,16'h0000,0,1,0,16'h0000, 1,0,16'h0300,0,1,16'hA5A5,0,0);
      vecs[19] = mk(0,0,16'h0000,0,0,1,16'hFFFF, 1,0,16'h0300,0,2,16'hFFFF,0,0);
      vecs[20] = mk(0,0,16'h0000,0,0,0,16'h0000, 0,0,16'h0300,1,2,16'hFFFF,1,0);
      vecs[21] = mk(0,1,16'h0400,4,0,0,16'h0000, 1,1,16'h0400,0,2,16'hFFFF,0,0);
      vecs[22] = mk(0,0,16'h0000,0,1,0,16'h0000, 1,0,16'h0400,0,2,16'hFFFF,0,0);
      vecs[23] = mk(1,0,16'h0000,0,0,0,16'h0000, 0,0,16'h0000,0,0,16'h0000,0,0);
      vecs[24] = mk(0,0,16'h0000,0,0,1,16'h5555, 0,0,16'h0000,0,0,16'h0000,0,0);
      vecs[25] = mk(0,0,16'h0000,0,0,0,16'h0000, 0,0,16'h0000,0,0,16'h0000,0,0);

      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vecs[i], i);
      end

      // Stalled grant (4 cycles low) and data (3 cycles late)
      reqCycles = 0; wbCount = 0; errCount = 0; wbSeen = '0;
      for (int k = 0; k < 15; k++) begin
         driveInputs(1'b0, k == 0, 16'h0500, 4'd6, k == 5, k == 9, (k == 9) ? 16'hC0DE : 16'h0000);
         reqCycles += int'(mem_req);
         wbCount   += int'(wb_en);
         errCount  += int'(err);
         if (wb_en) wbSeen = {wb_reg, wb_data};
      end
      checkOutput("stall_req_cycles", 64'(reqCycles), 64'd5);
      checkOutput("stall_wb_count", 64'(wbCount), 64'd1);
      checkOutput("stall_err_count", 64'(errCount), 64'd0);
      checkOutput("stall_wb_value", 64'(wbSeen), 64'h6C0DE);
      checkOutput("stall_idle_after", 64'(busy), 64'd0);

`ifdef LOAD_UNIT_TIMEOUT_EN
      // Grant never arrives: watchdog ends the load after 15 cycles in REQ
      reqCycles = 0; sawDone = 1'b0; doneErr = 1'b0; doneWb = 1'b1;
      for (int k = 0; k < 40; k++) begin
         driveInputs(1'b0, k == 0, 16'h0600, 4'd9, 1'b0, 1'b0, 16'h0000);
         reqCycles += int'(mem_req);
         if (done) begin
            sawDone = 1'b1; doneErr = err; doneWb = wb_en;
            break;
         end
      end
      checkOutput("wd_done_seen", 64'(sawDone), 64'd1);
      checkOutput("wd_err", 64'(doneErr), 64'd1);
      checkOutput("wd_wb_en", 64'(doneWb), 64'd0);
      checkOutput("wd_req_cycles", 64'(reqCycles), 64'd15);
      driveInputs(1'b0, 1'b1, 16'h0700, 4'd2, 1'b0, 1'b0, 16'h0000);
      checkOutput("wd_restart", 64'({mem_req, mem_addr, err}), 64'({1'b1, 16'h0700, 1'b0}));
`else
      // Grant never arrives and no watchdog: the unit waits indefinitely
      busyLow = 0; errCount = 0;
      for (int k = 0; k < 101; k++) begin
         driveInputs(1'b0, k == 0, 16'h0600, 4'd9, 1'b0, 1'b0, 16'h0000);
         busyLow  += int'(!busy);
         errCount += int'(err);
      end
      checkOutput("nowd_busy_low", 64'(busyLow), 64'd0);
      checkOutput("nowd_err", 64'(errCount), 64'd0);
      checkOutput("nowd_still_req", 64'({mem_req, done}), 64'({1'b1, 1'b0}));
`endif

      driveInputs(1'b1, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 16'h0000);
      checkOutput("final_reset", 64'({busy, mem_req, mem_addr, wb_en, done, err}), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 Parameter DATA_W, default 16, memory data and register write-back width.
REQ-002 Parameter ADDR_W, default 16, memory address width.
REQ-003 Parameter REG_W, default 4, destination register index width.
REQ-004 Parameter TIMEOUT_CYCLES, default 15, watchdog limit in cycles; used only when the timeout feature is compiled in.
REQ-005 Port clk input 1: the single clock; all logic on the rising edge.
REQ-006 Port reset input 1: reset is synchronous and active-high.
REQ-007 Port start input 1: load request from the LDR datapath, sampled on the rising edge.
REQ-008 Port addr_in input ADDR_W: load address, taken from register B.
REQ-009 Port dest_in input REG_W: destination register index.
REQ-010 Port busy output 1: high when state is not IDLE.
REQ-011 Port mem_req output 1: memory read request.
REQ-012 Port mem_addr output ADDR_W: latched load address.
REQ-013 Port mem_gnt input 1: memory accepts the request.
REQ-014 Port mem_rvalid input 1: read data valid.
REQ-015 Port mem_rdata input DATA_W: read data.
REQ-016 Port wb_en output 1: register-file write strobe.
REQ-017 Port wb_reg output REG_W: write-back register index.
REQ-018 Port wb_data output DATA_W: write-back data.
REQ-019 Port done output 1: one-cycle completion pulse.
REQ-020 Port err output 1: one-cycle timeout pulse, coincident with done.

Function
REQ-021 States: IDLE, REQ, WAIT, WB; encoding is binary.
- IDLE->REQ on start: latch addr_in and dest_in.
- REQ->WAIT on mem_gnt.
- WAIT->WB on mem_rvalid: capture mem_rdata.
- WB->IDLE unconditionally.
REQ-022 Output timing for mem_req: high exactly while in REQ, with mem_addr held stable throughout.
REQ-023 Output timing for WB state: wb_en and done high for exactly one cycle; wb_reg and wb_data valid during that cycle; all three zero otherwise.
REQ-024 Start handling outside IDLE: start is ignored.
REQ-025 Rvalid handling outside WAIT: mem_rvalid is ignored; mem_rvalid in the same cycle as mem_gnt is ignored.
REQ-026 Minimum latency: start at edge N, mem_gnt at N+1 and mem_rvalid at N+2 give wb_en high in the cycle following edge N+3; a new start is accepted at N+4.
REQ-027 Width handling: mem_rdata passes unmodified, with no extension or truncation.
REQ-028 Latch stability: wb_data and wb_reg hold their latched values after WB until the next capture.

Reset
REQ-029 Reset action: when reset is high at a rising edge, state becomes IDLE and every output register clears to 0.
- Covers busy, mem_req, mem_addr, wb_en, wb_reg, wb_data, done and err.
- Any watchdog counter also clears.
REQ-030 Reset mid-operation: reset abandons the load with no write-back and no done; late mem_rvalid after reset is ignored.

Configuration
REQ-031 Macro LOAD_UNIT_TIMEOUT_EN controls the watchdog.
- Defined: a counter clears on entry to REQ and increments each cycle in REQ or WAIT.
- Defined: on reaching TIMEOUT_CYCLES with no exit, the FSM returns to IDLE next edge with done=1, err=1 and wb_en=0 for one cycle.
- Defined: a normal exit in the same cycle as the limit wins.
- Undefined: no counter exists and err is tied to 0.

Structure
REQ-032 Package unicycle_pkg holds the shared items.
- The FSM state typedef.
- Default DATA_W, ADDR_W and REG_W constants shared with the STR path.
REQ-033 Sub-module load_timeout_ctr holds the watchdog counter and is instantiated only under LOAD_UNIT_TIMEOUT_EN.

Verification
REQ-034 Basic load: addr_in=0x0040, dest_in=3, start; mem_gnt next cycle; mem_rdata=0xBEEF with rvalid the cycle after -> mem_addr=0x0040 during REQ, then a single wb_en with wb_reg=3 and wb_data=0xBEEF, done=1 and err=0.
REQ-035 Stalled grant and data: mem_gnt held low 4 cycles, then rvalid delayed 3 cycles -> mem_req high exactly 5 cycles; exactly one wb_en; no err with timeout limit 15.
REQ-036 Ignored inputs: start with addr_in=0x1234 pulsed during WAIT; rvalid pulsed during REQ -> first load completes with its original address; no second request; the stray rvalid is not captured.
REQ-037 Reset mid-operation: reset asserted in WAIT, then rvalid with 0x5555 -> outputs 0, state IDLE, wb_en never asserted.
REQ-038 Watchdog fires: with LOAD_UNIT_TIMEOUT_EN defined and TIMEOUT_CYCLES=15, mem_gnt never asserted -> done=1, err=1, wb_en=0 after 15 cycles in REQ; next start accepted.
REQ-039 Watchdog absent: without LOAD_UNIT_TIMEOUT_EN, mem_gnt never asserted for 100 cycles -> busy stays 1, err stays 0.
